// File: rtl/lpc_target_bridge_pkg.sv
// Shared LPC definitions: start codes, SYNC codes, cycle-type fields, target FSM states.
package lpc_target_bridge_pkg;

    localparam logic [3:0] START_IO       = 4'b0000;
    localparam logic [3:0] START_TPM      = 4'b0101;

    localparam logic [3:0] SYNC_READY     = 4'b0000;
    localparam logic [3:0] SYNC_LONG_WAIT = 4'b0110;
    localparam logic [3:0] SYNC_ERROR     = 4'b1010;
    localparam logic [3:0] LAD_IDLE       = 4'hF;

    localparam int unsigned CT_DIR_BIT = 1;
    localparam int unsigned CT_TYPE_HI = 3;
    localparam int unsigned CT_TYPE_LO = 2;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'd0,
        ST_CYCTYPE = 5'd1,
        ST_ADDR0   = 5'd2,
        ST_ADDR1   = 5'd3,
        ST_ADDR2   = 5'd4,
        ST_ADDR3   = 5'd5,
        ST_WDATA0  = 5'd6,
        ST_WDATA1  = 5'd7,
        ST_TAR0    = 5'd8,
        ST_TAR1    = 5'd9,
        ST_SYNC    = 5'd10,
        ST_RDATA0  = 5'd11,
        ST_RDATA1  = 5'd12,
        ST_FTAR0   = 5'd13,
        ST_FTAR1   = 5'd14
    } lpc_state_e;

    typedef enum logic [1:0] {
        SD_READY = 2'd0,
        SD_WAIT  = 2'd1,
        SD_ERROR = 2'd2
    } sync_dec_e;

    function automatic logic addr_match(input logic [15:0] addr,
                                        input logic [15:0] base,
                                        input logic [15:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/lpc_target_bridge_sync_timer.sv
// Wait-state counter and ack latch; decides READY / LONG WAIT / ERROR for each SYNC cycle.
import lpc_target_bridge_pkg::*;

module lpc_sync_timer #(
    parameter int unsigned MAX_WAIT = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      clear_i,
    input  logic      req_i,
    input  logic      ack_i,
    input  logic      eval_i,
    output sync_dec_e dec_o,
    output logic      ack_take_o
);

    logic [7:0] wait_cnt;
    logic       ack_seen;

    // An ack only counts while the request is visible and the cycle is still owned.
    assign ack_take_o = ack_i & req_i & ~clear_i;

    always_comb begin
        if (ack_seen || ack_take_o) begin
            dec_o = SD_READY;
        end else if (wait_cnt < 8'(MAX_WAIT)) begin
            dec_o = SD_WAIT;
        end else begin
            dec_o = SD_ERROR;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            ack_seen <= 1'b0;
        end else if (clear_i) begin
            wait_cnt <= '0;
            ack_seen <= 1'b0;
        end else begin
            if (ack_take_o) begin
                ack_seen <= 1'b1;
            end
            if (eval_i && dec_o == SD_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/lpc_target_bridge.sv
// LPC I/O and TPM target: decodes cycles, forwards matches over req/ack, drives SYNC and read data.
import lpc_target_bridge_pkg::*;

module lpc_target_bridge #(
    parameter logic [15:0] IO_BASE  = 16'h0080,
    parameter logic [15:0] IO_MASK  = 16'hFFF0,
    parameter bit          TPM_EN   = 1'b1,
    parameter logic [15:0] TPM_BASE = 16'hD400,
    parameter logic [15:0] TPM_MASK = 16'hF000,
    parameter int unsigned MAX_WAIT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lframe_i,
    input  logic [3:0]  lad_i,
    output logic [3:0]  lad_o,
    output logic        lad_oe_o,
    output logic        req_o,
    output logic        wr_o,
    output logic        tpm_o,
    output logic [15:0] addr_o,
    output logic [7:0]  wdata_o,
    input  logic [7:0]  rdata_i,
    input  logic        ack_i,
    output logic        abort_o,
    output logic        err_o
);

    lpc_state_e  state_q, state_d;
    logic [11:0] addr_sh_q, addr_sh_d;
    logic [3:0]  wlo_q, wlo_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        is_tpm_q, is_tpm_d;
    logic        is_wr_q, is_wr_d;

    logic [3:0]  lad_d;
    logic        oe_d, req_d, wr_d, tpm_d, abort_d, err_d;
    logic [15:0] addr_d;
    logic [7:0]  wdata_d;

    logic [15:0] full_addr;
    logic        addr_hit, start_ok, abort_hit, ack_take;
    sync_dec_e   sync_dec;

    assign full_addr = {addr_sh_q, lad_i};
    assign addr_hit  = is_tpm_q ? (TPM_EN && addr_match(full_addr, TPM_BASE, TPM_MASK))
                                : addr_match(full_addr, IO_BASE, IO_MASK);
    assign start_ok  = (lad_i == START_IO) || (TPM_EN && lad_i == START_TPM);
    assign abort_hit = !lframe_i && state_q != ST_IDLE;

    lpc_sync_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sync_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (state_q == ST_IDLE || abort_hit),
        .req_i      (req_o),
        .ack_i      (ack_i),
        .eval_i     (state_q == ST_SYNC),
        .dec_o      (sync_dec),
        .ack_take_o (ack_take)
    );

    always_comb begin
        state_d   = state_q;
        addr_sh_d = addr_sh_q;
        wlo_d     = wlo_q;
        rdata_d   = ack_take ? rdata_i : rdata_q;
        is_tpm_d  = is_tpm_q;
        is_wr_d   = is_wr_q;
        lad_d     = lad_o;
        oe_d      = lad_oe_o;
        req_d     = req_o;
        wr_d      = wr_o;
        tpm_d     = tpm_o;
        addr_d    = addr_o;
        wdata_d   = wdata_o;
        abort_d   = 1'b0;
        err_d     = 1'b0;

        if (abort_hit) begin
            lad_d    = LAD_IDLE;
            oe_d     = 1'b0;
            req_d    = 1'b0;
            abort_d  = req_o | lad_oe_o;
            is_tpm_d = (lad_i == START_TPM);
            state_d  = start_ok ? ST_CYCTYPE : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!lframe_i && start_ok) begin
                        is_tpm_d = (lad_i == START_TPM);
                        state_d  = ST_CYCTYPE;
                    end
                end
                ST_CYCTYPE: begin
                    if (lad_i[CT_TYPE_HI:CT_TYPE_LO] != 2'b00) begin
                        state_d = ST_IDLE;
                    end else begin
                        is_wr_d = lad_i[CT_DIR_BIT];
                        state_d = ST_ADDR0;
                    end
                end
                ST_ADDR0: begin
                    addr_sh_d = {addr_sh_q[7:0], lad_i};
                    state_d   = ST_ADDR1;
                end
                ST_ADDR1: begin
                    addr_sh_d = {addr_sh_q[7:0], lad_i};
                    state_d   = ST_ADDR2;
                end
                ST_ADDR2: begin
                    addr_sh_d = {addr_sh_q[7:0], lad_i};
                    state_d   = ST_ADDR3;
                end
                ST_ADDR3: begin
                    if (addr_hit) begin
                        addr_d = full_addr;
                        wr_d   = is_wr_q;
                        tpm_d  = is_tpm_q;
                        if (is_wr_q) begin
                            state_d = ST_WDATA0;
                        end else begin
                            req_d   = 1'b1;
                            state_d = ST_TAR0;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WDATA0: begin
                    wlo_d   = lad_i;
                    state_d = ST_WDATA1;
                end
                ST_WDATA1: begin
                    wdata_d = {lad_i, wlo_q};
                    req_d   = 1'b1;
                    state_d = ST_TAR0;
                end
                ST_TAR0: begin
                    state_d = ST_TAR1;
                end
                // Output drive is registered, so LAD takes 4'hF one cycle before the SYNC code.
                ST_TAR1: begin
                    lad_d   = LAD_IDLE;
                    oe_d    = 1'b1;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    unique case (sync_dec)
                        SD_READY: begin
                            lad_d   = SYNC_READY;
                            req_d   = 1'b0;
                            state_d = is_wr_q ? ST_FTAR0 : ST_RDATA0;
                        end
                        SD_WAIT: begin
                            lad_d = SYNC_LONG_WAIT;
                        end
                        default: begin
                            lad_d   = SYNC_ERROR;
                            req_d   = 1'b0;
                            err_d   = 1'b1;
                            rdata_d = 8'hFF;
                            state_d = is_wr_q ? ST_FTAR0 : ST_RDATA0;
                        end
                    endcase
                end
                ST_RDATA0: begin
                    lad_d   = rdata_q[3:0];
                    state_d = ST_RDATA1;
                end
                ST_RDATA1: begin
                    lad_d   = rdata_q[7:4];
                    state_d = ST_FTAR0;
                end
                ST_FTAR0: begin
                    lad_d   = LAD_IDLE;
                    oe_d    = 1'b1;
                    state_d = ST_FTAR1;
                end
                ST_FTAR1: begin
                    lad_d   = LAD_IDLE;
                    oe_d    = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_sh_q <= '0;
            wlo_q     <= '0;
            rdata_q   <= '0;
            is_tpm_q  <= 1'b0;
            is_wr_q   <= 1'b0;
            lad_o     <= LAD_IDLE;
            lad_oe_o  <= 1'b0;
            req_o     <= 1'b0;
            wr_o      <= 1'b0;
            tpm_o     <= 1'b0;
            addr_o    <= '0;
            wdata_o   <= '0;
            abort_o   <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_sh_q <= addr_sh_d;
            wlo_q     <= wlo_d;
            rdata_q   <= rdata_d;
            is_tpm_q  <= is_tpm_d;
            is_wr_q   <= is_wr_d;
            lad_o     <= lad_d;
            lad_oe_o  <= oe_d;
            req_o     <= req_d;
            wr_o      <= wr_d;
            tpm_o     <= tpm_d;
            addr_o    <= addr_d;
            wdata_o   <= wdata_d;
            abort_o   <= abort_d;
            err_o     <= err_d;
        end
    end

endmodule

// File: tb/tb_lpc_target_bridge.sv
// Directed bench for lpc_target_bridge: transaction-level timeline model plus literal bus-trace pins.
module tb_lpc_target_bridge;

    localparam int unsigned MW       = 4;
    localparam logic [15:0] IO_BASE  = 16'h0080;
    localparam logic [15:0] IO_MASK  = 16'hFFF0;
    localparam logic [15:0] TPM_BASE = 16'hD400;
    localparam logic [15:0] TPM_MASK = 16'hF000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        lframe_i;
    logic [3:0]  lad_i;
    logic [3:0]  lad_o;
    logic        lad_oe_o;
    logic        req_o;
    logic        wr_o;
    logic        tpm_o;
    logic [15:0] addr_o;
    logic [7:0]  wdata_o;
    logic [7:0]  rdata_i;
    logic        ack_i;
    logic        abort_o;
    logic        err_o;

    always #5 clk = ~clk;

    lpc_target_bridge #(
        .IO_BASE  (IO_BASE),
        .IO_MASK  (IO_MASK),
        .TPM_EN   (1'b1),
        .TPM_BASE (TPM_BASE),
        .TPM_MASK (TPM_MASK),
        .MAX_WAIT (MW)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .lframe_i (lframe_i),
        .lad_i    (lad_i),
        .lad_o    (lad_o),
        .lad_oe_o (lad_oe_o),
        .req_o    (req_o),
        .wr_o     (wr_o),
        .tpm_o    (tpm_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .rdata_i  (rdata_i),
        .ack_i    (ack_i),
        .abort_o  (abort_o),
        .err_o    (err_o)
    );

    typedef struct packed {
        logic       oe;
        logic [3:0] lad;
        logic       req;
        logic       err;
        logic       abort;
    } exp_t;

    localparam exp_t EXP_IDLE = '{oe: 1'b0, lad: 4'hF, req: 1'b0, err: 1'b0, abort: 1'b0};

    int n_chk  = 0;
    int n_pass = 0;

    exp_t        cur_exp   = EXP_IDLE;
    bit          cur_valid = 1'b0;
    logic [15:0] cur_addr;
    logic        cur_wr;
    logic        cur_tpm;
    logic [7:0]  cur_wdata;
    logic [3:0]  drv_q[$];
    int          err_cnt;
    int          abort_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare process: checks every cycle against the expectation posted by the stimulus.
    always @(negedge clk) begin
        if (cur_valid && !rst_i) begin
            check("lad_oe", 32'(lad_oe_o), 32'(cur_exp.oe));
            if (cur_exp.oe) check("lad", 32'(lad_o), 32'(cur_exp.lad));
            check("req", 32'(req_o), 32'(cur_exp.req));
            check("err", 32'(err_o), 32'(cur_exp.err));
            check("abort", 32'(abort_o), 32'(cur_exp.abort));
            if (cur_exp.req) begin
                check("addr", 32'(addr_o), 32'(cur_addr));
                check("wr", 32'(wr_o), 32'(cur_wr));
                check("tpm", 32'(tpm_o), 32'(cur_tpm));
                if (cur_wr) check("wdata", 32'(wdata_o), 32'(cur_wdata));
            end
            if (lad_oe_o) drv_q.push_back(lad_o);
            if (err_o) err_cnt++;
            if (abort_o) abort_cnt++;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_lad"}, 32'(lad_o), 32'h0000000F);
        check({tag, "_oe"}, 32'(lad_oe_o), 32'd0);
        check({tag, "_req"}, 32'(req_o), 32'd0);
        check({tag, "_wr"}, 32'(wr_o), 32'd0);
        check({tag, "_tpm"}, 32'(tpm_o), 32'd0);
        check({tag, "_addr"}, 32'(addr_o), 32'd0);
        check({tag, "_wdata"}, 32'(wdata_o), 32'd0);
        check({tag, "_abort"}, 32'(abort_o), 32'd0);
        check({tag, "_err"}, 32'(err_o), 32'd0);
    endtask

    task automatic check_drv(input string name, input logic [63:0] v, input int n);
        check({name, "_len"}, 32'(drv_q.size()), 32'(n));
        for (int i = 0; i < n && i < drv_q.size(); i++) begin
            check(name, 32'(drv_q[i]), 32'(v[4*(n-1-i) +: 4]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            lframe_i  = 1'b1;
            lad_i     = 4'hF;
            ack_i     = 1'b0;
            rdata_i   = 8'($urandom);
            cur_exp   = EXP_IDLE;
            cur_valid = 1'b1;
        end
    endtask

    // Interval 1 carries the start nibble; the model lays out the whole owned cycle from it.
    task automatic lpc_txn(input bit wr, input bit tpm, input logic [15:0] addr,
                           input logic [7:0] data, input int ack_at, input int abort_at,
                           input int rst_at, output int last_state);
        logic [3:0] hl[64];
        logic       hf[64];
        exp_t       ex[64];
        int         d, sync_f, n, fin, len;
        bit         match, timeout;
        logic [7:0] rd;

        d     = wr ? 2 : 0;
        match = tpm ? ((addr & TPM_MASK) == (TPM_BASE & TPM_MASK))
                    : ((addr & IO_MASK) == (IO_BASE & IO_MASK));
        for (int i = 0; i < 64; i++) begin
            hf[i] = 1'b1;
            hl[i] = 4'hF;
            ex[i] = EXP_IDLE;
        end
        hf[1] = 1'b0;
        hl[1] = tpm ? 4'b0101 : 4'b0000;
        hl[2] = {2'b00, wr, 1'b0};
        hl[3] = addr[15:12];
        hl[4] = addr[11:8];
        hl[5] = addr[7:4];
        hl[6] = addr[3:0];
        if (wr) begin
            hl[7] = data[3:0];
            hl[8] = data[7:4];
        end
        sync_f = 9 + d;
        if (!match) begin
            len = 14;
        end else begin
            timeout = (ack_at < 7 + d) || (ack_at > sync_f + int'(MW));
            n   = timeout ? int'(MW) : ((ack_at <= sync_f) ? 0 : ack_at - sync_f);
            fin = sync_f + 1 + n;
            rd  = timeout ? 8'hFF : data;
            for (int i = 7 + d; i < fin; i++) ex[i].req = 1'b1;
            ex[sync_f].oe = 1'b1;
            for (int i = sync_f + 1; i < fin; i++) begin
                ex[i].oe  = 1'b1;
                ex[i].lad = 4'b0110;
            end
            ex[fin].oe  = 1'b1;
            ex[fin].lad = timeout ? 4'b1010 : 4'b0000;
            ex[fin].err = timeout;
            if (!wr) begin
                ex[fin+1].oe  = 1'b1;
                ex[fin+1].lad = rd[3:0];
                ex[fin+2].oe  = 1'b1;
                ex[fin+2].lad = rd[7:4];
                ex[fin+3].oe  = 1'b1;
                len = fin + 4;
            end else begin
                ex[fin+1].oe = 1'b1;
                len = fin + 2;
            end
        end
        if (abort_at > 0) begin
            hf[abort_at] = 1'b0;
            hl[abort_at] = 4'hF;
            for (int i = abort_at + 1; i < 64; i++) ex[i] = EXP_IDLE;
            ex[abort_at+1].abort = ex[abort_at].req | ex[abort_at].oe;
            len = abort_at + 3;
        end
        last_state = len - 1;

        drv_q.delete();
        err_cnt   = 0;
        abort_cnt = 0;
        cur_addr  = addr;
        cur_wr    = wr;
        cur_tpm   = tpm;
        cur_wdata = data;
        for (int i = 1; i <= len; i++) begin
            @(posedge clk); #1;
            lframe_i  = hf[i];
            lad_i     = hl[i];
            ack_i     = (i == ack_at) || (abort_at > 0 && i == abort_at + 1);
            rdata_i   = ack_i ? data : 8'($urandom);
            cur_exp   = ex[i];
            cur_valid = 1'b1;
            if (i == rst_at) begin
                @(negedge clk); #1;
                cur_valid = 1'b0;
                check("pre_rst_oe", 32'(lad_oe_o), 32'd1);
                rst_i = 1'b1;
                #1;
                check_reset_values("async_rst");
                @(posedge clk); #1;
                rst_i    = 1'b0;
                lframe_i = 1'b1;
                lad_i    = 4'hF;
                ack_i    = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int last;
        rst_i    = 1'b1;
        lframe_i = 1'b1;
        lad_i    = 4'hF;
        ack_i    = 1'b0;
        rdata_i  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_i = 1'b0;
        idle(2);

        // IO read, ack in TAR0: 13 clocks, LAD F,0,5,A,F
        lpc_txn(1'b0, 1'b0, 16'h0084, 8'hA5, 7, 0, 0, last);
        check("rd_clocks", 32'(last), 32'd13);
        idle(2);
        check_drv("rd_seq", 64'hF05AF, 5);

        // IO write, ack after three SYNC cycles
        lpc_txn(1'b1, 1'b0, 16'h0081, 8'h3C, 14, 0, 0, last);
        idle(2);
        check_drv("wr_seq", 64'hF6660F, 6);

        // TPM read, no ack: timeout error
        lpc_txn(1'b0, 1'b1, 16'hD410, 8'h00, 0, 0, 0, last);
        idle(2);
        check_drv("tpm_to_seq", 64'hF6666AFFF, 9);
        check("tpm_err_pulses", 32'(err_cnt), 32'd1);

        // IO read, address outside window
        lpc_txn(1'b0, 1'b0, 16'h0100, 8'h00, 7, 0, 0, last);
        idle(2);
        check("nomatch_drive", 32'(drv_q.size()), 32'd0);

        // Abort during SYNC, then a normal read
        lpc_txn(1'b0, 1'b0, 16'h0084, 8'h00, 0, 11, 0, last);
        idle(2);
        check("abort_pulses", 32'(abort_cnt), 32'd1);
        lpc_txn(1'b0, 1'b0, 16'h0085, 8'h5A, 8, 0, 0, last);
        idle(2);
        check_drv("post_abort_seq", 64'hF0A5F, 5);

        // TPM write, ack on the very cycle the wait budget runs out: ack wins
        lpc_txn(1'b1, 1'b1, 16'hD400, 8'h77, 15, 0, 0, last);
        idle(2);
        check_drv("ack_at_to_seq", 64'hF66660F, 7);
        check("ack_at_to_err", 32'(err_cnt), 32'd0);

        // Ack pulse before req_o is visible is ignored -> timeout
        lpc_txn(1'b0, 1'b0, 16'h008F, 8'h42, 6, 0, 0, last);
        idle(2);
        check("early_ack_err", 32'(err_cnt), 32'd1);

        // Asynchronous reset in RDATA0, then a normal read
        lpc_txn(1'b0, 1'b0, 16'h0084, 8'hA5, 7, 0, 10, last);
        cur_valid = 1'b0;
        lpc_txn(1'b0, 1'b0, 16'h0084, 8'hC3, 7, 0, 0, last);
        idle(2);
        check_drv("post_rst_seq", 64'hF03CF, 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lpc_target_bridge.md
Name: lpc_target_bridge

Overview:
Parametrised LPC target that decodes full LPC I/O and TPM read/write cycles: I/O and TPM start codes, 16-bit address, both directions. Matching cycles are forwarded to host logic through a req/ack register-bus handshake. Long-wait SYNC is inserted until the host answers, and an error SYNC is returned on timeout. The block sits between the board-level LAD tristate and the TPM register file, replacing the fixed-response read-only responder.

Parameters:
IO_BASE, 16'h0080, I/O cycle base address
IO_MASK, 16'hFFF0, address bits compared for I/O match (1 = compare)
TPM_EN, 1, accept TPM cycles (start code 4'b0101)
TPM_BASE, 16'hD400, TPM cycle base address
TPM_MASK, 16'hF000, address bits compared for TPM match
MAX_WAIT, 32, long-wait SYNC cycles before error SYNC (1..255)

Ports:
clk_i  in  1  LPC clock (33 MHz), all logic on rising edge
rst_i  in  1  reset, asynchronous, active-high
lframe_i  in  1  LFRAME#, active-low
lad_i  in  4  sampled LAD
lad_o  out  4  LAD drive value
lad_oe_o  out  1  LAD output enable (top-level tristate)
req_o  out  1  host request, held until ack_i
wr_o  out  1  1 = write, 0 = read; valid with req_o
tpm_o  out  1  1 = TPM cycle, 0 = I/O; valid with req_o
addr_o  out  16  cycle address; valid with req_o
wdata_o  out  8  write data; valid with req_o when wr_o = 1
rdata_i  in  8  read data, sampled when ack_i = 1
ack_i  in  1  host completion, single-cycle pulse
abort_o  out  1  one-cycle pulse when an LFRAME# abort hits an owned cycle
err_o  out  1  one-cycle pulse when an error SYNC is driven

Behaviour:
- Reset (asynchronous, active-high) forces state IDLE. Output reset values: lad_o = 4'hF, lad_oe_o = 0, req_o = 0, wr_o = 0, tpm_o = 0, addr_o = 0, wdata_o = 0, abort_o = 0, err_o = 0. The wait counter clears to 0.
- States: IDLE, CYCTYPE, ADDR0..ADDR3, WDATA0..1, TAR0..1, SYNC, RDATA0..1, FTAR0..1.
- IDLE -> CYCTYPE when lframe_i = 0 and lad_i = 4'b0000 (I/O). The same applies to lad_i = 4'b0101 when TPM_EN = 1; latch tpm.
- Start nibble repeated while lframe_i stays low: remain in CYCTYPE and re-latch tpm.
- CYCTYPE, sampled with lframe_i = 1: lad_i[3:2] must be 00, else go to IDLE. lad_i[1] = direction (1 = write). Next state ADDR0.
- ADDR0..ADDR3: address shifted in MSB nibble first.
- Address match: (addr & MASK) == (BASE & MASK) for the selected type.
- No match at end of ADDR3: go to IDLE and never drive LAD.
- Matched read: req_o asserts the cycle after ADDR3 (entry to TAR0).
- Matched write: go to WDATA0/1, low nibble first. req_o asserts on entry to TAR0.
- TAR0, TAR1: lad_oe_o = 0. At TAR1 the registered outputs are staged so lad_o = 4'hF and lad_oe_o = 1 in the first SYNC cycle, one cycle ahead of the SYNC value.
- SYNC, evaluated every cycle:
  - ack received (this cycle or earlier, latched): drive 4'b0000 READY, drop req_o, capture rdata_i.
  - otherwise, wait counter < MAX_WAIT: drive 4'b0110 LONG WAIT and increment the counter.
  - otherwise: drive 4'b1010 ERROR, drop req_o, pulse err_o, load read data 8'hFF.
- ack_i in the same cycle as timeout: ack wins and READY is driven.
- ack_i while req_o = 0: ignored.
- After SYNC: read -> RDATA0 (low nibble), RDATA1 (high nibble), then FTAR0 driving 4'hF with oe = 1, then FTAR1 with oe = 0, then IDLE. Write -> FTAR0, FTAR1 with the same drive pattern.
- Latency: host acking in TAR0 gives zero wait states. Read cycle total = 13 clocks, start through FTAR1.
- Abort: lframe_i = 0 in any non-IDLE state
  - force lad_oe_o = 0 and drop req_o next cycle;
  - pulse abort_o if req_o was set or LAD was driven;
  - go to CYCTYPE if lad_i is a valid start code, else IDLE.
- A late ack_i after an abort is ignored.

Decomposition:
- Shared package/defines (extend the existing LPC defines):
  - start codes 4'b0000 / 4'b0101;
  - SYNC codes READY 4'b0000, LONG_WAIT 4'b0110, ERROR 4'b1010;
  - cycle-type field positions;
  - state encoding (5-bit constants).
- One sub-module is natural: lpc_sync_timer, the wait counter plus ack latch, deciding READY / WAIT / ERROR.
- The FSM and shift registers stay in the top module.

Test Plan:
- IO read 0x0084, ack_i in TAR0 with rdata 8'hA5 -> addr_o = 16'h0084, wr_o = 0; LAD driven 0000, 5, A, F then released; 13 clocks total.
- IO write 0x0081, data 8'h3C, ack after 3 cycles in SYNC -> wdata_o = 8'h3C, three 0110 SYNCs then 0000; LAD released after FTAR1.
- TPM read 0xD410, no ack, MAX_WAIT = 4 -> four 0110, one 1010, err_o pulse, data nibbles F, F.
- IO read 0x0100 (no match) -> lad_oe_o stays 0 and req_o stays 0 for the whole cycle.
- Abort: lframe_i low with lad 4'b1111 during SYNC of a matched read -> lad_oe_o = 0 and req_o = 0 next cycle, abort_o pulses once, state IDLE; a following valid IO read completes normally.
- Reset asserted mid-RDATA0 -> lad_oe_o = 0 immediately (asynchronous), all outputs at reset values, FSM in IDLE.
